// File: rtl/gpio_cmd_pkg.sv
// Shared opcodes, FSM encoding and GPIO word layout for the GPIO command sequencer.
package gpio_cmd_pkg;

  // gpo word layout: [31:24] opcode, [23] enable, [22:0] data
  localparam int unsigned OPC_MSB      = 31;
  localparam int unsigned OPC_LSB      = 24;
  localparam int unsigned EN_BIT       = 23;
  localparam int unsigned DATA_MSB     = 22;
  localparam int unsigned DATA_USE_MSB = 19;  // highest data bit any opcode consumes
  localparam int unsigned DATA_USE_W   = DATA_USE_MSB + 1;

  // gpi read-data field width
  localparam int unsigned RD_W = 30;

  // Command opcodes
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SOFT_RST = 8'h01;
  localparam logic [7:0] OP_SET_LEDS = 8'h02;
  localparam logic [7:0] OP_GET_SW   = 8'h03;
  localparam logic [7:0] OP_REG_WR   = 8'h04;
  localparam logic [7:0] OP_REG_RD   = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_PULSE = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  // gpi word payload returned to firmware
  typedef struct packed {
    logic            ack;
    logic            err;
    logic [RD_W-1:0] rd;
  } gpi_t;

endpackage

// File: rtl/gpio_cmd_regfile.sv
// 16x16 register file: synchronous write, combinational read, flattened view of all entries.
module gpio_cmd_regfile
  import gpio_cmd_pkg::*;
#(
  parameter int unsigned NB_ADDR = 4,
  parameter int unsigned NB_DATA = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [NB_ADDR-1:0]             waddr,
  input  logic [NB_DATA-1:0]             wdata,
  input  logic [NB_ADDR-1:0]             raddr,
  output logic [NB_DATA-1:0]             rdata_c,
  output logic [(NB_DATA<<NB_ADDR)-1:0]  rf_flat
);

  localparam int unsigned DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  // Storage with async clear and single write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

  // Entry k lands at [k*NB_DATA +: NB_DATA]
  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign rf_flat[k*NB_DATA +: NB_DATA] = mem[k];
  end

endmodule

// File: rtl/gpio_cmd_ctrl.sv
// Command sequencer between MicroBlaze GPIO and board resources (LEDs, switches, regfile, soft reset).
module gpio_cmd_ctrl
  import gpio_cmd_pkg::*;
#(
  parameter int unsigned NB_GPIOS         = 32,
  parameter int unsigned NB_LEDS          = 2,
  parameter int unsigned NB_RGB           = 12,
  parameter int unsigned NB_REG_ADDR      = 4,
  parameter int unsigned NB_REG_DATA      = 16,
  parameter int unsigned RST_PULSE_CYCLES = 16
) (
  input  logic                                  clockdsp,
  input  logic                                  in_reset,
  input  logic [NB_GPIOS-1:0]                   in_gpo,
  input  logic [3:0]                            in_sw,
  output logic [NB_GPIOS-1:0]                   out_gpi,
  output logic [NB_LEDS-1:0]                    out_leds,
  output logic [NB_RGB-1:0]                     out_leds_rgb,
  output logic                                  out_soft_rst,
  output logic [(NB_REG_DATA<<NB_REG_ADDR)-1:0] out_rf
);

  localparam int unsigned CNT_W = $clog2(RST_PULSE_CYCLES + 1);

  state_t                  state;
  logic                    en_q;
  logic                    armed;
  logic [7:0]              opc_q;
  logic [DATA_USE_W-1:0]   data_q;
  logic [CNT_W-1:0]        cnt;
  gpi_t                    gpi_q;
  logic [NB_LEDS-1:0]      leds_q;
  logic [NB_RGB-1:0]       rgb_q;
  logic                    soft_rst_q;

  logic                    en_c;
  logic                    rise_c;
  logic                    rf_we_c;
  logic [NB_REG_DATA-1:0]  rf_rdata_c;
  logic                    unused_gpo_c;

  assign en_c         = in_gpo[EN_BIT];
  assign rise_c       = en_c && !en_q && armed;
  assign rf_we_c      = (state == ST_EXEC) && (opc_q == OP_REG_WR);
  assign unused_gpo_c = ^in_gpo[DATA_MSB:DATA_USE_W];

  // Register file, written during EXEC of REG_WR
  gpio_cmd_regfile #(
    .NB_ADDR (NB_REG_ADDR),
    .NB_DATA (NB_REG_DATA)
  ) u_regfile (
    .clk     (clockdsp),
    .rst     (in_reset),
    .we      (rf_we_c),
    .waddr   (data_q[19:16]),
    .wdata   (data_q[15:0]),
    .raddr   (data_q[19:16]),
    .rdata_c (rf_rdata_c),
    .rf_flat (out_rf)
  );

  // Command FSM with edge detect, arming and all registered outputs
  always_ff @(posedge clockdsp or posedge in_reset) begin
    if (in_reset) begin
      state      <= ST_IDLE;
      en_q       <= 1'b0;
      armed      <= 1'b0;
      opc_q      <= '0;
      data_q     <= '0;
      cnt        <= '0;
      gpi_q      <= '0;
      leds_q     <= '0;
      rgb_q      <= '0;
      soft_rst_q <= 1'b0;
    end else begin
      en_q <= en_c;
      if (!en_c) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (rise_c) begin
            opc_q  <= in_gpo[OPC_MSB:OPC_LSB];
            data_q <= in_gpo[DATA_USE_MSB:0];
            state  <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          state     <= ST_ACK;
          gpi_q.ack <= 1'b1;
          gpi_q.err <= 1'b0;
          case (opc_q)
            OP_NOP, OP_REG_WR: ;
            OP_SOFT_RST: begin
              soft_rst_q <= 1'b1;
              cnt        <= CNT_W'(RST_PULSE_CYCLES - 1);
              gpi_q.ack  <= 1'b0;
              state      <= ST_PULSE;
            end
            OP_SET_LEDS: begin
              rgb_q  <= data_q[11:0];
              leds_q <= data_q[13:12];
            end
            OP_GET_SW: gpi_q.rd <= RD_W'(in_sw);
            OP_REG_RD: gpi_q.rd <= RD_W'(rf_rdata_c);
            default:   gpi_q.err <= 1'b1;
          endcase
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            soft_rst_q <= 1'b0;
            gpi_q.ack  <= 1'b1;
            state      <= ST_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_ACK: begin
          if (!en_c) begin
            gpi_q.ack <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_gpi      = gpi_q;
  assign out_leds     = leds_q;
  assign out_leds_rgb = rgb_q;
  assign out_soft_rst = soft_rst_q;

endmodule
